// File: rtl/interrupt_line_driver_pkg.sv
// Shared CPU/bus constants for the interrupt line driver: source count,
// bus width and the register map.
package interrupt_line_driver_pkg;

    localparam int NUM_SOURCES = 16;
    localparam int BUS_WIDTH   = 32;

    localparam logic [1:0] ADDR_PENDING  = 2'd0;  // R: pending, W: 1-to-clear
    localparam logic [1:0] ADDR_MODE     = 2'd1;  // R/W: 0 level, 1 edge
    localparam logic [1:0] ADDR_SET      = 2'd2;  // W: 1-to-set, R: 0
    localparam logic [1:0] ADDR_RESERVED = 2'd3;  // R: 0, W: ignored

    typedef logic [NUM_SOURCES-1:0] srcVec_t;

    // Zero-extend a source vector onto the bus.
    function automatic logic [BUS_WIDTH-1:0] toBus(input srcVec_t value);
        return {{(BUS_WIDTH-NUM_SOURCES){1'b0}}, value};
    endfunction

endpackage

// File: rtl/interrupt_line_driver_sync.sv
// Two-flop synchronizer bringing asynchronous event inputs into the clock
// domain. Width-parameterized; one instance covers all sources.
module Synchronizer2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] syncOut
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= asyncIn;
            s2 <= s1;
        end
    end

    assign syncOut = s2;

endmodule

// File: rtl/interrupt_line_driver.sv
// Interrupt line driver: synchronizes 16 device events, latches them as
// level or edge pending bits, and exposes pending/mode/set registers on a
// simple strobe/ack bus. interruptLines is the pending register itself.
module interrupt_line_driver
    import interrupt_line_driver_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] eventInputs,
    input  logic                   busStrobe,
    input  logic                   busWrite,
    input  logic [1:0]             busAddress,
    input  logic [BUS_WIDTH-1:0]   busDataIn,
    output logic [BUS_WIDTH-1:0]   busDataOut,
    output logic                   busAck,
    output logic [NUM_SOURCES-1:0] interruptLines
);

    srcVec_t s2;
    srcVec_t prev;
    srcVec_t pending;
    srcVec_t mode;

    srcVec_t clearMask;
    srcVec_t setMask;
    srcVec_t pendingNext;
    srcVec_t writeData;
    logic    accept;
    logic    doWrite;
    logic [BUS_WIDTH-1:0] readData;

    // Upper write-data bits have no register behind them.
    logic unusedDataHigh;
    assign unusedDataHigh = ^busDataIn[BUS_WIDTH-1:NUM_SOURCES];

    Synchronizer2 #(.WIDTH(NUM_SOURCES)) eventSync (
        .clock   (clock),
        .reset   (reset),
        .asyncIn (eventInputs),
        .syncOut (s2)
    );

    assign writeData = busDataIn[NUM_SOURCES-1:0];
    // busAck high means the previous cycle was accepted; a held strobe must
    // not be taken twice.
    assign accept    = busStrobe && !busAck;
    assign doWrite   = accept && busWrite;

    // Bus decode and next pending value. Level bits track s2 and ignore the
    // bus; edge bits are sticky, and a rising edge or software set beats a
    // same-cycle clear. The current mode governs this edge, so a mode write
    // takes effect on the following cycle.
    always_comb begin
        clearMask = '0;
        setMask   = '0;
        readData  = '0;
        if (doWrite && busAddress == ADDR_PENDING) clearMask = writeData;
        if (doWrite && busAddress == ADDR_SET)     setMask   = writeData;
        if (accept && !busWrite) begin
            case (busAddress)
                ADDR_PENDING: readData = toBus(pending);
                ADDR_MODE:    readData = toBus(mode);
                default:      readData = '0;
            endcase
        end
        pendingNext = (~mode & s2)
                    | ( mode & ((pending & ~clearMask) | (s2 & ~prev) | setMask));
    end

    // Edge-detect history behind the synchronizer.
    always_ff @(posedge clock) begin
        if (reset) prev <= '0;
        else       prev <= s2;
    end

    // Pending and mode registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            mode    <= '0;
        end else begin
            pending <= pendingNext;
            if (doWrite && busAddress == ADDR_MODE) mode <= writeData;
        end
    end

    // One-cycle ack with read data; data bus is zero whenever ack is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            busAck     <= 1'b0;
            busDataOut <= '0;
        end else begin
            busAck     <= accept;
            busDataOut <= readData;
        end
    end

    assign interruptLines = pending;

endmodule

// File: doc/interrupt_line_driver.md
INTERRUPT_LINE_DRIVER -- requirements
Module: interrupt_line_driver

Interface
REQ-001 SHALL have parameter none; register map and widths fixed (16 sources, 32-bit bus data).
REQ-002 SHALL have ports: clock  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: eventInputs  in  16  asynchronous device interrupt events, one per source.
REQ-005 SHALL have ports: busStrobe  in  1  bus cycle request; held high until busAck.
REQ-006 SHALL have ports: busWrite  in  1  1 = write, 0 = read; valid with busStrobe.
REQ-007 SHALL have ports: busAddress  in  2  register select; valid with busStrobe.
REQ-008 SHALL have ports: busDataIn  in  32  write data; bits 15:0 used, 31:16 ignored.
REQ-009 SHALL have ports: busDataOut  out  32  read data; bits 31:16 always 0.
REQ-010 SHALL have ports: busAck  out  1  single-cycle transaction completion.
REQ-011 SHALL have ports: interruptLines  out  16  registered pending bits, drive the CPU's 16 external interrupt lines.

Function
REQ-012 SHALL pass each eventInputs bit through a 2-flop synchronizer (s1, s2) plus a history flop prev <= s2.
REQ-013 SHALL hold mode[15:0]: bit=0 level source, bit=1 edge source.
REQ-014 SHALL, for a level source, load pending[i] <= s2[i] every cycle; bus clear/set ignored for that bit.
REQ-015 SHALL, for an edge source, set pending[i] when s2[i] & !prev[i]; bit stays set until cleared by bus.
REQ-016 SHALL make pending visible on interruptLines at the 3rd rising edge after (and counting) the first edge sampling eventInputs[i] high; interruptLines == pending always.
REQ-017 SHALL decode address 0: read pending; write 1-to-clear edge-mode bits.
REQ-018 SHALL decode address 1: read/write mode; a bit switched edge->level takes s2 next cycle; level->edge keeps current pending value.
REQ-019 SHALL decode address 2: write 1-to-set edge-mode pending bits; reads return 0.
REQ-020 SHALL decode address 3: reads return 0, writes ignored.
REQ-021 SHALL, on the same edge, let hardware edge-set or software set win over a W1C clear of the same bit.
REQ-022 SHALL accept a transaction on a cycle with busStrobe=1 and busAck=0; register update and busAck=1 plus busDataOut occur at the following edge.
REQ-023 SHALL deassert busAck the cycle after it pulses, so a held strobe yields exactly one transaction per two cycles; no write applies twice.
REQ-024 SHALL drive busDataOut = 0 whenever busAck = 0.
REQ-025 SHALL sample read data at the accepting edge (pre-write state of the same cycle not applicable: reads have no side effects).

Reset
REQ-026 SHALL, on reset=1 at a rising edge, clear s1, s2, prev, pending, mode (all level), busAck, busDataOut to 0.
REQ-027 SHALL abandon a transaction in flight when reset asserts; no ack is issued for it; strobe held across reset release is accepted as new.
REQ-028 SHALL keep interruptLines = 0 while reset is high regardless of eventInputs.

Structure
REQ-029 SHALL place register address constants (0..3) and source count (16) in the shared CPU/bus constants package.
REQ-030 SHALL use one sub-module, Synchronizer2 (2-flop, width-parameterized), instantiated once 16 bits wide.
REQ-031 SHALL keep pending and mode update logic and bus decode in the top module; no other hierarchy.

Verification
REQ-032 SHALL cover: level mode, eventInputs[3] high at edge N -> interruptLines[3]=1 after edge N+2; input low -> line low 3 edges later.
REQ-033 SHALL cover: write mode=0x0001, pulse eventInputs[0] one cycle -> interruptLines[0] latches 1; write addr 0 data 0x0001 -> line 0 after ack edge.
REQ-034 SHALL cover: edge rising on bit 0 at same edge as W1C 0x0001 -> pending[0] stays 1.
REQ-035 SHALL cover: mode=0xFFFF, write addr 2 0x8000 -> interruptLines=0x8000; read addr 0 -> busDataOut=0x00008000 with one busAck pulse; strobe held 4 cycles -> exactly 2 acks.
REQ-036 SHALL cover: reset asserted mid-transaction with pending=0xFFFF -> no ack, all outputs 0 next edge, mode reads 0 afterwards.
